m_uart_tx: RTL
==============

# m_uart_tx

UART transmitter with an integrated bit-period generator. Accepts bytes over a valid/ready handshake and serialises each as an 8N1 frame (8E1 when parity is compiled in), LSB first, on `o_uart_tx`. Sits on the outbound side of the UART command path and pairs with the existing receive chain at the same baud rate and clock period. The line idles high.

## Interface
- `UART_BPS_RATE`, default 115200: baud rate in bps, must be ≤115200.
- `CLK_PERIORD`, default 20: clock period in ns.
- Derived localparam `BPS_CNT_MAX = 1000_000_000/UART_BPS_RATE/CLK_PERIORD-1`. Defaults give 433, so one bit is 434 cycles.

Ports:
- `i_clk` in 1: system clock.
- `i_rst` in 1: one clock; reset is synchronous and active-high.
- `i_tx_data` in 8: byte to send, sampled on handshake.
- `i_tx_valid` in 1: byte available.
- `o_tx_ready` out 1: high only in IDLE. Handshake completes on a rising edge where `i_tx_valid & o_tx_ready`.
- `o_uart_tx` out 1: serial line, registered.
- `o_tx_busy` out 1: high from the cycle after acceptance to the end of the stop bit.
- `o_tx_done` out 1: one-cycle pulse on frame completion.

## Operation
- **Reset values**:
  - `o_uart_tx`=1, `o_tx_ready`=1, `o_tx_busy`=0, `o_tx_done`=0.
  - State IDLE, bit counter 0, shift register 0.
- **States**: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- **IDLE**:
  - `o_uart_tx`=1.
  - On handshake: latch `i_tx_data` into the shift register and go to START.
  - On that same edge: `o_uart_tx`←0, `o_tx_ready`←0, `o_tx_busy`←1, `r_bps_cnt`←0.
- **Bit timing**: 16-bit `r_bps_cnt` increments every cycle outside IDLE. At `BPS_CNT_MAX` it wraps to 0 and the bit ends.
- **START**: drive 0 for one bit, then go to DATA with bit index 0.
- **DATA**:
  - Drive `shift[0]`. At each bit end, shift right and increment the 3-bit index.
  - After index 7 ends, go to PARITY (macro on) or STOP.
- **PARITY**: drive the even-parity bit (XOR of the latched byte) for one bit, then go to STOP.
- **STOP**:
  - Drive 1 for one bit.
  - At its end: state←IDLE, `o_tx_ready`←1, `o_tx_busy`←0, `o_tx_done`←1 for exactly one cycle.
- `o_uart_tx` is always a register output with no combinational path from inputs.
- `i_tx_data` and `i_tx_valid` are ignored while not ready. Changing `i_tx_data` mid-frame does not affect the frame.
- **Reset mid-frame**: on the next edge all outputs return to their reset values. The line goes high, the frame is aborted and no `o_tx_done` is emitted.

## Timing
- Handshake at edge T: the start bit occupies cycles T+1 … T+434 (defaults).
- Data bit k occupies T+1+434·(k+1) onward, 434 cycles each.
- Frame length on line: 10·434 = 4340 cycles, or 11·434 = 4774 with parity.
- `o_tx_done` and `o_tx_ready` both rise in the first cycle after the stop bit. `o_tx_done` is high one cycle only.
- Back-to-back with `i_tx_valid` held high:
  - The next handshake occurs on the first edge with `o_tx_ready`=1.
  - That leaves exactly one idle-high cycle between the stop bit and the next start bit.
  - Frame-to-frame period: 4341 cycles (4775 with parity).
- `r_bps_cnt` never exceeds `BPS_CNT_MAX` and is 0 in IDLE.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined**: PARITY state is compiled in. Frames are 8E1, 11 bits, parity = ^data so the total count of ones across data and parity is even.
- **Undefined**: the PARITY state and its logic are absent. Frames are 8N1, 10 bits, and DATA goes directly to STOP.

## Test plan
- **Reset**: assert `i_rst` 3 cycles → `o_uart_tx`=1, `o_tx_ready`=1, `o_tx_busy`=0, `o_tx_done`=0. Assert reset mid-DATA → line high next cycle, no done pulse.
- **Single byte 0xA5 (8N1, defaults)**:
  - Line reads 0, 1,0,1,0,0,1,0,1, 1; each level held 434 cycles.
  - `o_tx_done` is a single pulse 4340 cycles after the first start-bit cycle.
- **Back-to-back 0x00 then 0xFF, valid held high**:
  - Two correct frames.
  - Exactly one idle-high cycle between them.
  - Two `o_tx_done` pulses 4341 cycles apart.
- **Ignored while busy**: toggle `i_tx_valid` and change `i_tx_data` during a frame → frame content unchanged, no extra frame sent.
- **Parity (`UART_TX_PARITY_EN` defined)**: send 0x07 → parity bit 1. Send 0x03 → parity bit 0. Frame is 4774 cycles.
- **Non-default params**: `UART_BPS_RATE`=9600, `CLK_PERIORD`=10 → each bit is 10416 cycles and the counter does not overflow 16 bits.

Source files
------------

// File: rtl/m_uart_tx.sv
// m_uart_tx: UART transmitter with built-in bit-period generator.
// Accepts a byte on a valid/ready handshake and sends it LSB first as an
// 8N1 frame, or as 8E1 when UART_TX_PARITY_EN is defined. The line idles high.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
module m_uart_tx #(
    parameter int UART_BPS_RATE = 115200,
    parameter int CLK_PERIORD   = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_uart_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    // Cycles per bit minus one; the bit counter wraps here.
    localparam int          BPS_CNT_MAX = 1000_000_000 / UART_BPS_RATE / CLK_PERIORD - 1;
    localparam logic [15:0] BPS_END     = 16'(BPS_CNT_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      state_reg,   state_next;
    logic [15:0] r_bps_cnt,   bps_cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg,   shift_next;
    logic        tx_reg,      tx_next;
    logic        ready_reg,   ready_next;
    logic        busy_reg,    busy_next;
    logic        done_reg,    done_next;
`ifdef UART_TX_PARITY_EN
    // Parity is captured at acceptance because the shift register is consumed.
    logic        parity_reg,  parity_next;
`endif
    logic        bit_end;

    assign bit_end    = (r_bps_cnt == BPS_END);
    assign o_uart_tx  = tx_reg;
    assign o_tx_ready = ready_reg;
    assign o_tx_busy  = busy_reg;
    assign o_tx_done  = done_reg;

    // State and output registers; every output is driven straight from a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            r_bps_cnt   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            r_bps_cnt   <= bps_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            ready_reg   <= ready_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    // Next-state logic: the line value for the coming bit is decided on the
    // edge that ends the current bit, so o_uart_tx changes exactly at bit boundaries.
    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        ready_next   = ready_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        if (state_reg == S_IDLE || bit_end) begin
            bps_cnt_next = '0;
        end else begin
            bps_cnt_next = r_bps_cnt + 16'd1;
        end

        case (state_reg)
            S_IDLE: begin
                tx_next = 1'b1;
                if (i_tx_valid && ready_reg) begin
                    shift_next  = i_tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^i_tx_data;
`endif
                    state_next  = S_START;
                    tx_next     = 1'b0;
                    ready_next  = 1'b0;
                    busy_next   = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next   = S_DATA;
                    bit_idx_next = 3'd0;
                    tx_next      = shift_reg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
                        tx_next    = parity_reg;
`else
                        state_next = S_STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        tx_next = shift_reg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                    tx_next    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_next = S_IDLE;
                    tx_next    = 1'b1;
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule
